// File: rtl/snake_render.sv
// rtl/snake_render.sv - frame-snapshotted two-stage pixel colour pipeline for the snake game
module snake_render #(
  parameter int MAX_LEN      = 14,
  parameter int BLOCK_W      = 20,
  parameter int SIDE_W       = 20,
  parameter int H_DISP       = 640,
  parameter int V_DISP       = 480,
  parameter int FLASH_FRAMES = 15
) (
  input  logic                    vga_clk,
  input  logic                    sys_rst,
  input  logic                    frame_start,
  input  logic                    pix_valid,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic [MAX_LEN*10-1:0]   snake_x_flat,
  input  logic [MAX_LEN*10-1:0]   snake_y_flat,
  input  logic [12:0]             snake_cur_len,
  input  logic [9:0]              food_x,
  input  logic [9:0]              food_y,
  input  logic                    die,
  output logic [15:0]             pix_data,
  output logic                    pix_data_valid
);

  localparam int CW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [15:0] C_BLACK  = 16'h0000;
  localparam logic [15:0] C_YELLOW = 16'hFFE0;
  localparam logic [15:0] C_GREEN  = 16'h07E0;
  localparam logic [15:0] C_RED    = 16'hF800;
  localparam logic [15:0] C_GREY   = 16'h8410;

  typedef enum logic {ST_ALIVE, ST_DEAD} flash_state_e;

  // Shadow copy of the game state, frozen for the whole frame.
  logic [MAX_LEN*10-1:0] shx_q, shy_q;
  logic [12:0]           len_q;
  logic [9:0]            food_x_q, food_y_q;

  // Flash state: the DEAD state doubles as the shadow of the die flag.
  flash_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // Stage 1 results.
  logic [MAX_LEN-1:0] seg_hit_d, seg_hit_q;
  logic               food_hit_d, food_hit_q;
  logic               wall_hit_d, wall_hit_q;
  logic               valid1_q;

  // Stage 2 colour.
  logic [15:0] colour_d;

  // The view of the game state used by stage 1: the snapshot being taken this
  // cycle is already visible to the pixel sampled alongside frame_start.
  logic [MAX_LEN*10-1:0] cur_x, cur_y;
  logic [12:0]           cur_len, eff_len;
  logic [9:0]            cur_fx, cur_fy;

  function automatic logic in_box(input logic [9:0] px, input logic [9:0] py,
                                  input logic [9:0] bx, input logic [9:0] by);
    logic [10:0] xe, ye;
    xe = {1'b0, bx} + 11'(BLOCK_W);
    ye = {1'b0, by} + 11'(BLOCK_W);
    return (px >= bx) && ({1'b0, px} < xe) && (py >= by) && ({1'b0, py} < ye);
  endfunction

  // Capture the game state into the shadows on every frame_start.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      shx_q    <= {MAX_LEN{10'd100}};
      shy_q    <= {MAX_LEN{10'd100}};
      len_q    <= 13'd1;
      food_x_q <= 10'd200;
      food_y_q <= 10'd200;
    end else if (frame_start) begin
      shx_q    <= snake_x_flat;
      shy_q    <= snake_y_flat;
      len_q    <= snake_cur_len;
      food_x_q <= food_x;
      food_y_q <= food_y;
    end
  end

  // Flash state register.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_ALIVE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Flash next state: only frame_start moves it, die is sampled at that moment.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      case (state_q)
        ST_ALIVE: begin
          if (die) begin
            state_d = ST_DEAD;
            cnt_d   = '0;
            phase_d = 1'b0;
          end
        end
        ST_DEAD: begin
          if (!die) begin
            state_d = ST_ALIVE;
            cnt_d   = '0;
            phase_d = 1'b0;
          end else if (cnt_q == CW'(FLASH_FRAMES - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_ALIVE;
      endcase
    end
  end

  // Stage 1 hit tests against the frame's game state.
  always_comb begin
    cur_x   = frame_start ? snake_x_flat  : shx_q;
    cur_y   = frame_start ? snake_y_flat  : shy_q;
    cur_len = frame_start ? snake_cur_len : len_q;
    cur_fx  = frame_start ? food_x        : food_x_q;
    cur_fy  = frame_start ? food_y        : food_y_q;
    if (cur_len == 13'd0)
      eff_len = 13'd1;
    else if (cur_len > 13'(MAX_LEN))
      eff_len = 13'(MAX_LEN);
    else
      eff_len = cur_len;
    seg_hit_d = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_hit_d[i] = (13'(i) < eff_len) &&
                     in_box(pix_x, pix_y, cur_x[i*10 +: 10], cur_y[i*10 +: 10]);
    end
    food_hit_d = in_box(pix_x, pix_y, cur_fx, cur_fy);
    wall_hit_d = ({1'b0, pix_x} < 11'(SIDE_W)) ||
                 ({1'b0, pix_x} >= 11'(H_DISP - SIDE_W)) ||
                 ({1'b0, pix_y} < 11'(SIDE_W)) ||
                 ({1'b0, pix_y} >= 11'(V_DISP - SIDE_W));
  end

  // Stage 1 pipeline register.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      seg_hit_q  <= '0;
      food_hit_q <= 1'b0;
      wall_hit_q <= 1'b0;
      valid1_q   <= 1'b0;
    end else begin
      seg_hit_q  <= seg_hit_d;
      food_hit_q <= food_hit_d;
      wall_hit_q <= wall_hit_d;
      valid1_q   <= pix_valid;
    end
  end

  // Stage 2 colour priority: head, body, food, wall, background.
  always_comb begin
    colour_d = C_BLACK;
    if (!valid1_q)
      colour_d = C_BLACK;
    else if (seg_hit_q[0])
      colour_d = ((state_q == ST_DEAD) && phase_q) ? C_RED : C_YELLOW;
    else if (|seg_hit_q[MAX_LEN-1:1])
      colour_d = ((state_q == ST_DEAD) && phase_q) ? C_RED : C_GREEN;
    else if (food_hit_q)
      colour_d = C_RED;
    else if (wall_hit_q)
      colour_d = C_GREY;
  end

  // Stage 2 output register.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pix_data       <= 16'h0000;
      pix_data_valid <= 1'b0;
    end else begin
      pix_data       <= colour_d;
      pix_data_valid <= valid1_q;
    end
  end

endmodule

// File: tb/tb_snake_render.sv
// tb/tb_snake_render.sv - directed vector bench for snake_render
module tb_snake_render;

  localparam int ML = 14;

  logic           vga_clk = 1'b0;
  logic           sys_rst = 1'b1;
  logic           frame_start = 1'b0;
  logic           pix_valid = 1'b0;
  logic [9:0]     pix_x = '0, pix_y = '0;
  logic [ML*10-1:0] snake_x_flat = '0, snake_y_flat = '0;
  logic [12:0]    snake_cur_len = '0;
  logic [9:0]     food_x = '0, food_y = '0;
  logic           die = 1'b0;
  logic [15:0]    pix_data;
  logic           pix_data_valid;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        v;
    logic [15:0] d;
    logic        dv;
  } vec_t;

  vec_t tbl[$];
  logic [9:0] sx[ML];
  logic [9:0] sy[ML];
  int n_vec = 0;
  int n_miss = 0;

  snake_render dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .snake_x_flat(snake_x_flat), .snake_y_flat(snake_y_flat),
    .snake_cur_len(snake_cur_len), .food_x(food_x), .food_y(food_y),
    .die(die), .pix_data(pix_data), .pix_data_valid(pix_data_valid)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic pack();
    for (int i = 0; i < ML; i++) begin
      snake_x_flat[i*10 +: 10] = sx[i];
      snake_y_flat[i*10 +: 10] = sy[i];
    end
  endtask

  task automatic pulse();
    @(negedge vga_clk); frame_start = 1'b1;
    @(negedge vga_clk); frame_start = 1'b0;
  endtask

  task automatic snap();
    pack();
    pulse();
  endtask

  task automatic chk(input logic [9:0] x, input logic [9:0] y, input logic v,
                     input logic [15:0] d, input logic dv);
    @(negedge vga_clk);
    pix_x = x; pix_y = y; pix_valid = v;
    @(posedge vga_clk); @(posedge vga_clk); #1;
    n_vec++;
    if (pix_data !== d || pix_data_valid !== dv) begin
      n_miss++;
      $display("FAIL vec %0d pix(%0d,%0d,v=%b): got data=%h valid=%b, want data=%h valid=%b",
               n_vec, x, y, v, pix_data, pix_data_valid, d, dv);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++)
      chk(tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].d, tbl[i].dv);
    tbl.delete();
  endtask

  logic [15:0] pat;

  initial begin
    for (int i = 0; i < ML; i++) begin sx[i] = '0; sy[i] = '0; end

    // Reset state
    repeat (3) @(posedge vga_clk);
    #1;
    n_vec++;
    if (pix_data !== 16'h0000 || pix_data_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_state: got data=%h valid=%b, want 0000/0", pix_data, pix_data_valid);
    end
    @(negedge vga_clk); sys_rst = 1'b0;

    // Reset shadows, no frame_start yet
    tbl.push_back('{10'd105, 10'd110, 1'b1, 16'hFFE0, 1'b1});
    tbl.push_back('{10'd205, 10'd205, 1'b1, 16'hF800, 1'b1});
    tbl.push_back('{10'd5,   10'd5,   1'b1, 16'h8410, 1'b1});
    tbl.push_back('{10'd300, 10'd300, 1'b1, 16'h0000, 1'b1});
    tbl.push_back('{10'd105, 10'd110, 1'b0, 16'h0000, 1'b0});
    tbl.push_back('{10'd635, 10'd475, 1'b1, 16'h8410, 1'b1});
    run_table();

    // Head + one body segment, slot 2 parked beyond length
    food_x = 10'd500; food_y = 10'd400;
    sx[0] = 10'd140; sy[0] = 10'd100;
    sx[1] = 10'd120; sy[1] = 10'd100;
    sx[2] = 10'd300; sy[2] = 10'd300;
    snake_cur_len = 13'd2;
    snap();
    tbl.push_back('{10'd125, 10'd105, 1'b1, 16'h07E0, 1'b1});
    tbl.push_back('{10'd145, 10'd105, 1'b1, 16'hFFE0, 1'b1});
    tbl.push_back('{10'd159, 10'd119, 1'b1, 16'hFFE0, 1'b1});
    tbl.push_back('{10'd160, 10'd105, 1'b1, 16'h0000, 1'b1});
    tbl.push_back('{10'd140, 10'd120, 1'b1, 16'h0000, 1'b1});
    tbl.push_back('{10'd139, 10'd105, 1'b1, 16'h07E0, 1'b1});
    tbl.push_back('{10'd305, 10'd305, 1'b1, 16'h0000, 1'b1});
    tbl.push_back('{10'd505, 10'd405, 1'b1, 16'hF800, 1'b1});
    run_table();

    // Inputs move without frame_start: picture must not change
    sx[0] = 10'd160; pack();
    chk(10'd145, 10'd105, 1'b1, 16'hFFE0, 1'b1);
    chk(10'd165, 10'd105, 1'b1, 16'h0000, 1'b1);

    // len=0 clamps to head only; head over the wall hides the wall
    sx[0] = 10'd0; sy[0] = 10'd300; snake_cur_len = 13'd0;
    snap();
    chk(10'd5,   10'd305, 1'b1, 16'hFFE0, 1'b1);
    chk(10'd125, 10'd105, 1'b1, 16'h0000, 1'b1);

    // Head near the top of the 10-bit range: box end must not wrap
    sx[0] = 10'd1010; snake_cur_len = 13'd1;
    snap();
    chk(10'd1015, 10'd305, 1'b1, 16'hFFE0, 1'b1);

    // len=20 clamps to all 14 slots; food under slot 3 is hidden
    for (int i = 0; i < ML; i++) begin
      sx[i] = 10'(40 + 40 * i); sy[i] = 10'd200;
    end
    food_x = 10'd160; food_y = 10'd200;
    snake_cur_len = 13'd20;
    snap();
    for (int i = 0; i < ML; i++)
      chk(sx[i] + 10'd5, 10'd205, 1'b1, (i == 0) ? 16'hFFE0 : 16'h07E0, 1'b1);
    chk(10'd65, 10'd205, 1'b1, 16'h0000, 1'b1);

    // Death blink
    for (int i = 2; i < ML; i++) begin sx[i] = 10'd300; sy[i] = 10'd300; end
    sx[0] = 10'd140; sy[0] = 10'd100;
    sx[1] = 10'd120; sy[1] = 10'd100;
    snake_cur_len = 13'd2;
    food_x = 10'd500; food_y = 10'd400;
    die = 1'b1;
    snap();
    chk(10'd145, 10'd105, 1'b1, 16'hFFE0, 1'b1);
    for (int f = 1; f <= 30; f++) begin
      pulse();
      chk(10'd145, 10'd105, 1'b1, (f < 15 || f == 30) ? 16'hFFE0 : 16'hF800, 1'b1);
      if (f == 14) chk(10'd125, 10'd105, 1'b1, 16'h07E0, 1'b1);
      if (f == 15) chk(10'd125, 10'd105, 1'b1, 16'hF800, 1'b1);
      if (f == 20) begin
        die = 1'b0;
        chk(10'd145, 10'd105, 1'b1, 16'hF800, 1'b1);
        die = 1'b1;
      end
    end
    pulse();
    pulse();
    pulse();
    pulse();
    pulse();
    pulse();
    pulse();
    pulse();
    pulse();
    pulse();
    pulse();
    pulse();
    pulse();
    pulse();
    pulse();
    chk(10'd145, 10'd105, 1'b1, 16'hF800, 1'b1);
    die = 1'b0;
    pulse();
    chk(10'd145, 10'd105, 1'b1, 16'hFFE0, 1'b1);
    chk(10'd125, 10'd105, 1'b1, 16'h07E0, 1'b1);

    // pix_data_valid follows pix_valid two cycles late
    pix_x = 10'd300; pix_y = 10'd300;
    pat = 16'b1011_0010_1110_0101;
    for (int i = 0; i < 18; i++) begin
      @(negedge vga_clk);
      if (i >= 2) begin
        n_vec++;
        if (pix_data_valid !== pat[i-2]) begin
          n_miss++;
          $display("FAIL valid_delay step %0d: got %b, want %b", i, pix_data_valid, pat[i-2]);
        end
      end
      if (i < 16) pix_valid = pat[i];
    end

    // frame_start together with a valid pixel: snapshot applies to that pixel
    sx[0] = 10'd400; sy[0] = 10'd300; pack();
    @(negedge vga_clk);
    frame_start = 1'b1; pix_x = 10'd405; pix_y = 10'd305; pix_valid = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0; pix_x = 10'd300; pix_y = 10'd300;
    @(posedge vga_clk); #1;
    n_vec++;
    if (pix_data !== 16'hFFE0) begin
      n_miss++;
      $display("FAIL same_cycle_snap: got %h, want ffe0", pix_data);
    end
    @(posedge vga_clk); #1;
    n_vec++;
    if (pix_data !== 16'h0000) begin
      n_miss++;
      $display("FAIL same_cycle_next: got %h, want 0000", pix_data);
    end

    // Asynchronous reset mid-line
    chk(10'd405, 10'd305, 1'b1, 16'hFFE0, 1'b1);
    #2 sys_rst = 1'b1;
    #1;
    n_vec++;
    if (pix_data !== 16'h0000 || pix_data_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL async_reset: got data=%h valid=%b, want 0000/0", pix_data, pix_data_valid);
    end
    @(negedge vga_clk); sys_rst = 1'b0;
    tbl.push_back('{10'd105, 10'd110, 1'b1, 16'hFFE0, 1'b1});
    tbl.push_back('{10'd205, 10'd205, 1'b1, 16'hF800, 1'b1});
    tbl.push_back('{10'd405, 10'd305, 1'b1, 16'h0000, 1'b1});
    run_table();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
